// File: rtl/tinytpu_pkg.sv
// Shared definitions for the tinytpu operand loader: default sizes, the loader
// FSM state type and the flat-bus element index helper.
package tinytpu_pkg;

  localparam int D_W_DEF = 8;
  localparam int N_DEF   = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    FULL = 2'd2
  } state_t;

  // Element k of a flat matrix bus lives at bits [k*D_W +: D_W].
  function automatic int idx(input int row, input int col, input int n = N_DEF);
    return row * n + col;
  endfunction

endpackage

// File: rtl/tinytpu_deser.sv
// One serial-to-parallel lane: a D_W-bit LSB-first shift register plus the bit
// counter that marks the cycle on which the final bit of a word arrives.
module tinytpu_deser #(
  parameter int D_W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clr_i,
  input  logic           shift_en_i,
  input  logic           bit_i,
  output logic [D_W-1:0] word_o,
  output logic           word_done_o
);

  localparam int CW = (D_W > 1) ? $clog2(D_W) : 1;

  logic [D_W-1:0] sr_q;
  logic [CW-1:0]  bit_cnt_q;
  logic           last_bit;

  assign last_bit = (bit_cnt_q == CW'(D_W - 1));

  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      sr_q      <= '0;
      bit_cnt_q <= '0;
    end else if (shift_en_i) begin
      sr_q      <= {bit_i, sr_q[D_W-1:1]};
      bit_cnt_q <= last_bit ? '0 : bit_cnt_q + 1'b1;
    end
  end

  // The completed word includes the bit arriving this cycle, so it can be
  // committed on the same edge that samples it.
  assign word_o      = {bit_i, sr_q[D_W-1:1]};
  assign word_done_o = shift_en_i && last_bit;

endmodule

// File: rtl/tinytpu_rx_loader.sv
// Bit-serial operand loader: deserialises matrix A and B streams into flat
// element buses and hands them to the systolic core with a valid/ready pair.
module tinytpu_rx_loader
  import tinytpu_pkg::*;
#(
  parameter  int D_W   = D_W_DEF,
  parameter  int N     = N_DEF,
  localparam int ELEMS = N * N,
  localparam int BUS_W = ELEMS * D_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             data_in_x,
  input  logic             data_in_y,
  input  logic             load_en,
  input  logic             init,
  output logic [BUS_W-1:0] a_flat,
  output logic [BUS_W-1:0] b_flat,
  output logic             mat_valid,
  input  logic             mat_ready,
  output logic             busy,
  output logic             overrun
);

  localparam int EW = (ELEMS > 1) ? $clog2(ELEMS) : 1;

  state_t           state_q;
  logic [EW-1:0]    elem_cnt_q, elem_cnt_d;
  logic [BUS_W-1:0] a_flat_q, b_flat_q;
  logic             mat_valid_q, busy_q, overrun_q;

  logic             shift_en;
  logic             last_elem;
  logic             wr_en;
  logic [D_W-1:0]   x_word, y_word;
  logic             x_done, y_done;

  // init wins over load_en, so a bit presented alongside init never shifts in.
  assign shift_en  = (state_q == LOAD) && load_en && !init;
  assign last_elem = (elem_cnt_q == EW'(ELEMS - 1));
  // Both lanes share shift_en and clear, so their strobes coincide exactly.
  assign wr_en     = x_done && y_done;

  always_comb begin
    elem_cnt_d = last_elem ? '0 : elem_cnt_q + 1'b1;
  end

  tinytpu_deser #(.D_W(D_W)) u_deser_x (
    .clk         (clk),
    .rst         (rst),
    .clr_i       (init),
    .shift_en_i  (shift_en),
    .bit_i       (data_in_x),
    .word_o      (x_word),
    .word_done_o (x_done)
  );

  tinytpu_deser #(.D_W(D_W)) u_deser_y (
    .clk         (clk),
    .rst         (rst),
    .clr_i       (init),
    .shift_en_i  (shift_en),
    .bit_i       (data_in_y),
    .word_o      (y_word),
    .word_done_o (y_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      elem_cnt_q  <= '0;
      a_flat_q    <= '0;
      b_flat_q    <= '0;
      mat_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
    end else if (init) begin
      // Old bus contents stay until each element is rewritten by the new frame.
      state_q     <= LOAD;
      elem_cnt_q  <= '0;
      mat_valid_q <= 1'b0;
      busy_q      <= 1'b1;
      overrun_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: ;
        LOAD: begin
          if (wr_en) begin
            a_flat_q[elem_cnt_q*D_W +: D_W] <= x_word;
            b_flat_q[elem_cnt_q*D_W +: D_W] <= y_word;
            elem_cnt_q <= elem_cnt_d;
            if (last_elem) begin
              state_q     <= FULL;
              mat_valid_q <= 1'b1;
              busy_q      <= 1'b0;
            end
          end
        end
        FULL: begin
          if (load_en) overrun_q <= 1'b1;
          if (mat_ready) begin
            state_q     <= LOAD;
            elem_cnt_q  <= '0;
            mat_valid_q <= 1'b0;
            busy_q      <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign a_flat    = a_flat_q;
  assign b_flat    = b_flat_q;
  assign mat_valid = mat_valid_q;
  assign busy      = busy_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_tinytpu_rx_loader.sv
// Bench for tinytpu_rx_loader (D_W=8, N=2): frame table, corner sequences and
// a randomized run against a bit-counting reference model.
module tb_tinytpu_rx_loader;
  import tinytpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst, dx, dy, load_en, init, mat_ready;
  logic [31:0] a_flat, b_flat;
  logic        mat_valid, busy, overrun;

  int total  = 0;
  int passed = 0;

  tinytpu_rx_loader #(.D_W(8), .N(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .data_in_x (dx),
    .data_in_y (dy),
    .load_en   (load_en),
    .init      (init),
    .a_flat    (a_flat),
    .b_flat    (b_flat),
    .mat_valid (mat_valid),
    .mat_ready (mat_ready),
    .busy      (busy),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] ea;
    logic [31:0] eb;
    int          gap;
    logic [31:0] exp_a;
    logic [31:0] exp_b;
  } vec_t;

  vec_t vecs[4];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else passed++;
  endtask

  // Streams 32 qualified bits; with gap>0 every gap-th cycle is an idle cycle.
  task automatic send_frame(input logic [31:0] ea, input logic [31:0] eb, input int gap);
    int i;
    int cyc;
    i = 0;
    cyc = 0;
    while (i < 32) begin
      if (gap > 0 && (cyc % gap) == gap - 1) begin
        load_en = 1'b0;
        dx = 1'($urandom);
        dy = 1'($urandom);
      end else begin
        load_en = 1'b1;
        dx = ea[i];
        dy = eb[i];
        i++;
        if (i == 32) begin
          chk("valid_before_last_bit", {31'd0, mat_valid}, 32'd0);
          chk("busy_in_frame", {31'd0, busy}, 32'd1);
        end
      end
      cyc++;
      tick();
    end
    load_en = 1'b0;
  endtask

  task automatic do_init();
    init = 1'b1;
    load_en = 1'b1;
    dx = 1'b1;
    dy = 1'b1;
    tick();
    init = 1'b0;
    load_en = 1'b0;
  endtask

  // Reference model: counts qualified bits of the current frame and commits an
  // element each time eight of its bits have been collected.
  int          m_mode;   // 0 idle, 1 loading, 2 full
  int          m_nbits;
  logic [31:0] m_pa, m_pb, m_a, m_b;
  logic        m_valid, m_over;

  task automatic model_step();
    int e;
    int k;
    if (rst) begin
      m_mode = 0; m_nbits = 0; m_a = 0; m_b = 0; m_valid = 0; m_over = 0;
    end else if (init) begin
      m_mode = 1; m_nbits = 0; m_valid = 0; m_over = 0;
    end else if (m_mode == 1) begin
      if (load_en) begin
        m_pa[m_nbits] = dx;
        m_pb[m_nbits] = dy;
        m_nbits++;
        if (m_nbits % 8 == 0) begin
          e = m_nbits / 8 - 1;
          k = idx(e / N_DEF, e % N_DEF);
          m_a[k*8 +: 8] = m_pa[k*8 +: 8];
          m_b[k*8 +: 8] = m_pb[k*8 +: 8];
        end
        if (m_nbits == 32) begin
          m_mode = 2; m_nbits = 0; m_valid = 1;
        end
      end
    end else if (m_mode == 2) begin
      if (load_en) m_over = 1;
      if (mat_ready) begin
        m_mode = 1; m_valid = 0;
      end
    end
  endtask

  initial begin
    vecs[0] = '{ea: {8'd4, 8'd3, 8'd2, 8'd1}, eb: {8'd8, 8'd7, 8'd6, 8'd5}, gap: 0,
                exp_a: 32'h04030201, exp_b: 32'h08070605};
    vecs[1] = '{ea: {8'd4, 8'd3, 8'd2, 8'd1}, eb: {8'd8, 8'd7, 8'd6, 8'd5}, gap: 3,
                exp_a: 32'h04030201, exp_b: 32'h08070605};
    vecs[2] = '{ea: {8'h00, 8'hFF, 8'h55, 8'hAA}, eb: {8'h80, 8'h01, 8'hFF, 8'h00}, gap: 0,
                exp_a: 32'h00FF55AA, exp_b: 32'h8001FF00};
    vecs[3] = '{ea: {8'd12, 8'd11, 8'd10, 8'd9}, eb: {8'hEF, 8'hBE, 8'hAD, 8'hDE}, gap: 2,
                exp_a: 32'h0C0B0A09, exp_b: 32'hEFBEADDE};

    rst = 1'b1; dx = 1'b0; dy = 1'b0; load_en = 1'b0; init = 1'b0; mat_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_a_flat", a_flat, 32'd0);
    chk("rst_b_flat", b_flat, 32'd0);
    chk("rst_flags", {29'd0, mat_valid, busy, overrun}, 32'd0);

    // Frame table
    for (int v = 0; v < 4; v++) begin
      do_init();
      chk("init_busy", {31'd0, busy}, 32'd1);
      send_frame(vecs[v].ea, vecs[v].eb, vecs[v].gap);
      chk("frame_valid", {31'd0, mat_valid}, 32'd1);
      chk("frame_busy_full", {31'd0, busy}, 32'd0);
      chk("frame_a", a_flat, vecs[v].exp_a);
      chk("frame_b", b_flat, vecs[v].exp_b);
      chk("frame_overrun", {31'd0, overrun}, 32'd0);
      mat_ready = 1'b1;
      tick();
      mat_ready = 1'b0;
      chk("accept_valid", {31'd0, mat_valid}, 32'd0);
      chk("accept_busy", {31'd0, busy}, 32'd1);
    end

    // Overrun while FULL
    do_init();
    send_frame({8'd4, 8'd3, 8'd2, 8'd1}, {8'd8, 8'd7, 8'd6, 8'd5}, 0);
    for (int c = 0; c < 3; c++) begin
      load_en = 1'b1; dx = 1'($urandom); dy = 1'($urandom);
      tick();
    end
    load_en = 1'b0;
    chk("ovr_set", {31'd0, overrun}, 32'd1);
    chk("ovr_valid", {31'd0, mat_valid}, 32'd1);
    chk("ovr_a_hold", a_flat, 32'h04030201);
    chk("ovr_b_hold", b_flat, 32'h08070605);
    mat_ready = 1'b1;
    tick();
    mat_ready = 1'b0;
    chk("ovr_accept_valid", {31'd0, mat_valid}, 32'd0);
    chk("ovr_accept_busy", {31'd0, busy}, 32'd1);
    chk("ovr_sticky", {31'd0, overrun}, 32'd1);
    do_init();
    chk("ovr_cleared_by_init", {31'd0, overrun}, 32'd0);

    // Back-to-back frames with mat_ready held high
    mat_ready = 1'b1;
    send_frame({8'd4, 8'd3, 8'd2, 8'd1}, {8'd8, 8'd7, 8'd6, 8'd5}, 0);
    chk("b2b_valid1", {31'd0, mat_valid}, 32'd1);
    tick();
    chk("b2b_accepted", {31'd0, mat_valid}, 32'd0);
    chk("b2b_busy", {31'd0, busy}, 32'd1);
    send_frame({8'd12, 8'd11, 8'd10, 8'd9}, {8'd16, 8'd15, 8'd14, 8'd13}, 0);
    chk("b2b_valid2", {31'd0, mat_valid}, 32'd1);
    chk("b2b_a", a_flat, 32'h0C0B0A09);
    chk("b2b_b", b_flat, 32'h100F0E0D);
    chk("b2b_overrun", {31'd0, overrun}, 32'd0);
    mat_ready = 1'b0;

    // init mid-frame
    do_init();
    load_en = 1'b1; dx = 1'b1; dy = 1'b1;
    for (int c = 0; c < 13; c++) tick();
    chk("mid_partial_a", a_flat, 32'h0C0B0AFF);
    do_init();
    chk("mid_init_hold_a", a_flat, 32'h0C0B0AFF);
    chk("mid_init_valid", {31'd0, mat_valid}, 32'd0);
    send_frame({8'h00, 8'hFF, 8'h55, 8'hAA}, {8'h11, 8'h22, 8'h33, 8'h44}, 0);
    chk("mid_valid", {31'd0, mat_valid}, 32'd1);
    chk("mid_a", a_flat, 32'h00FF55AA);
    chk("mid_b", b_flat, 32'h11223344);

    // Reset mid-frame, then load_en without init
    do_init();
    load_en = 1'b1;
    for (int c = 0; c < 20; c++) begin
      dx = 1'($urandom); dy = 1'($urandom);
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rstmid_a", a_flat, 32'd0);
    chk("rstmid_b", b_flat, 32'd0);
    chk("rstmid_flags", {29'd0, mat_valid, busy, overrun}, 32'd0);
    for (int c = 0; c < 10; c++) begin
      dx = 1'($urandom); dy = 1'($urandom);
      tick();
    end
    load_en = 1'b0;
    chk("idle_a", a_flat, 32'd0);
    chk("idle_flags", {29'd0, mat_valid, busy, overrun}, 32'd0);

    // Randomized run against the reference model
    rst = 1'b1;
    model_step();
    tick();
    rst = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      rst       = ($urandom_range(0, 199) == 0);
      init      = ($urandom_range(0, 59) == 0);
      load_en   = ($urandom_range(0, 9) < 7);
      mat_ready = ($urandom_range(0, 4) == 0);
      dx        = 1'($urandom);
      dy        = 1'($urandom);
      model_step();
      tick();
      chk("rand_a", a_flat, m_a);
      chk("rand_b", b_flat, m_b);
      chk("rand_flags", {29'd0, mat_valid, busy, overrun},
          {29'd0, m_valid, (m_mode == 1), m_over});
    end
    rst = 1'b0; init = 1'b0; load_en = 1'b0; mat_ready = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
